// File: rtl/mr_fetch_controller.sv
// ---------------------------------------------------------------------------
// mr_fetch_controller : instruction fetch sequencer with branch redirection
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mr_fetch_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] pc,
  output logic        pc_ena,
  output logic        pc_st,
  output logic [15:0] pc_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_req,
  input  logic [15:0] br_addr,
  output logic        busy,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2,
    S_LOAD    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic        r_br_pend;
  logic [15:0] r_br_addr;
  logic [15:0] r_fetch_cnt;

  logic        w_ir_load;
  logic        w_handshake;
  logic        w_br_take;

  // A branch arriving during the load cycle would be lost anyway; ignore it.
  assign w_br_take   = br_req && (r_state != S_LOAD);
  assign w_handshake = ir_valid && ir_ready;

  assign mem_addr  = pc;
  assign busy      = (r_state != S_IDLE);
  assign ir        = r_ir;
  assign fetch_cnt = r_fetch_cnt;

  always_comb begin
    w_next    = r_state;
    pc_ena    = 1'b0;
    pc_st     = 1'b0;
    pc_addr   = 16'h0000;
    mem_req   = 1'b0;
    ir_valid  = 1'b0;
    w_ir_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_br_pend) begin
          w_next = S_LOAD;
        end else if (run) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          // A word fetched under a pending redirect belongs to the old path.
          if (r_br_pend || br_req) begin
            w_next = S_LOAD;
          end else begin
            pc_ena    = 1'b1;
            w_ir_load = 1'b1;
            w_next    = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        ir_valid = !r_br_pend;
        if (r_br_pend) begin
          w_next = S_LOAD;
        end else if (ir_ready) begin
          if (br_req) begin
            w_next = S_LOAD;
          end else if (run) begin
            w_next = S_REQ;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        pc_ena  = 1'b1;
        pc_st   = 1'b1;
        pc_addr = r_br_addr;
        w_next  = run ? S_REQ : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= 16'h0000;
    end else if (w_ir_load) begin
      r_ir <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_pend <= 1'b0;
      r_br_addr <= 16'h0000;
    end else if (r_state == S_LOAD) begin
      r_br_pend <= 1'b0;
    end else if (w_br_take) begin
      r_br_pend <= 1'b1;
      r_br_addr <= br_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 16'h0000;
    end else if (w_handshake) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mr_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_mr_fetch_controller : directed and random checks against a fetch model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mr_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] pc;
  logic        pc_ena;
  logic        pc_st;
  logic [15:0] pc_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_req;
  logic [15:0] br_addr;
  logic        busy;
  logic [15:0] fetch_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the fetcher is doing, in plain activity flags.
  bit          m_fetching;
  bit          m_holding;
  bit          m_loading;
  bit          m_pend;
  logic [15:0] m_target;
  logic [15:0] m_ir;
  logic [15:0] m_cnt;

  mr_fetch_controller dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .pc       (pc),
    .pc_ena   (pc_ena),
    .pc_st    (pc_st),
    .pc_addr  (pc_addr),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .br_req   (br_req),
    .br_addr  (br_addr),
    .busy     (busy),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetching = 1'b0;
    m_holding  = 1'b0;
    m_loading  = 1'b0;
    m_pend     = 1'b0;
    m_target   = 16'h0000;
    m_ir       = 16'h0000;
    m_cnt      = 16'h0000;
    pc         = 16'h0000;
  endtask

  // Entered at a falling edge; applies one cycle of inputs, checks every
  // output against the model, advances model and program counter, and
  // returns at the next falling edge.
  task automatic cycle(input bit i_run, input bit i_ack, input logic [15:0] i_data,
                       input bit i_rdy, input bit i_br, input logic [15:0] i_ba);
    bit          deliverable;
    bit          hs;
    bit          step_pc;
    logic [15:0] load_val;
    bit          nf;
    bit          nh;
    bit          nl;
    run      = i_run;
    mem_ack  = i_ack;
    mem_data = i_data;
    ir_ready = i_rdy;
    br_req   = i_br;
    br_addr  = i_ba;
    #1;
    deliverable = m_holding && !m_pend;
    hs          = deliverable && i_rdy;
    step_pc     = m_loading || (m_fetching && i_ack && !(m_pend || i_br));
    load_val    = m_loading ? m_target : 16'h0000;
    chk1("mem_req", mem_req, m_fetching);
    if (m_fetching) chk("mem_addr", mem_addr, pc);
    chk1("ir_valid", ir_valid, deliverable);
    chk("ir", ir, m_ir);
    chk1("pc_ena", pc_ena, step_pc);
    chk1("pc_st", pc_st, m_loading);
    chk("pc_addr", pc_addr, load_val);
    chk1("busy", busy, m_fetching || m_holding || m_loading);
    chk("fetch_cnt", fetch_cnt, m_cnt);
    @(posedge clk);
    nf = 1'b0;
    nh = 1'b0;
    nl = 1'b0;
    if (m_loading) begin
      nf = i_run;
    end else if (m_fetching) begin
      if (!i_ack) begin
        nf = 1'b1;
      end else if (m_pend || i_br) begin
        nl = 1'b1;
      end else begin
        m_ir = i_data;
        nh   = 1'b1;
      end
    end else if (m_holding) begin
      if (m_pend)      nl = 1'b1;
      else if (!hs)    nh = 1'b1;
      else if (i_br)   nl = 1'b1;
      else             nf = i_run;
    end else begin
      if (m_pend)      nl = 1'b1;
      else             nf = i_run;
    end
    if (hs) m_cnt = m_cnt + 16'd1;
    if (m_loading) begin
      m_pend = 1'b0;
    end else if (i_br) begin
      m_pend   = 1'b1;
      m_target = i_ba;
    end
    if (step_pc) pc = m_loading ? m_target : pc + 16'd1;
    m_fetching = nf;
    m_holding  = nh;
    m_loading  = nl;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    run      = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    ir_ready = 1'b0;
    br_req   = 1'b0;
    br_addr  = 16'h0000;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_pc_ena", pc_ena, 1'b0);
    chk1("rst_pc_st", pc_st, 1'b0);
    chk("rst_pc_addr", pc_addr, 16'h0000);
    chk1("rst_ir_valid", ir_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_cnt", fetch_cnt, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Basic fetch, ack one cycle after request
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    chk("f1_addr", mem_addr, 16'h0000);
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    cycle(0, 1, 16'hA5A5, 1, 0, 16'h0000);
    chk("f1_ir", ir, 16'hA5A5);
    cycle(0, 0, 16'h0000, 1, 0, 16'h0000);
    chk("f1_cnt", fetch_cnt, 16'h0001);
    chk1("f1_idle", busy, 1'b0);

    // Decoder stall for five cycles
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);
    cycle(0, 1, 16'h3C3C, 0, 0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 16'h0000, 0, 0, 16'h0000);
      chk("stall_ir", ir, 16'h3C3C);
      chk("stall_cnt", fetch_cnt, 16'h0001);
    end
    cycle(0, 0, 16'h0000, 1, 0, 16'h0000);
    chk("stall_cnt_done", fetch_cnt, 16'h0002);

    // Branch while requesting: fetched word discarded, target loaded
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);
    cycle(1, 0, 16'h0000, 0, 1, 16'h1234);
    cycle(1, 1, 16'hBEEF, 0, 0, 16'h0000);
    chk1("br_pc_st", pc_st, 1'b1);
    chk("br_pc_addr", pc_addr, 16'h1234);
    chk("br_ir_kept", ir, 16'h3C3C);
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);
    chk("br_mem_addr", mem_addr, 16'h1234);
    cycle(1, 1, 16'h7777, 1, 0, 16'h0000);
    cycle(0, 0, 16'h0000, 1, 0, 16'h0000);
    chk("br_cnt", fetch_cnt, 16'h0003);

    // Two branches before the ack: last one wins
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);
    cycle(1, 0, 16'h0000, 0, 1, 16'h1000);
    cycle(1, 0, 16'h0000, 0, 1, 16'h2000);
    cycle(1, 1, 16'h1111, 0, 0, 16'h0000);
    chk("br2_pc_addr", pc_addr, 16'h2000);
    chk("br2_cnt", fetch_cnt, 16'h0003);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000);
    chk1("br2_idle", busy, 1'b0);

    // Back-to-back fetches: one instruction every two cycles
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 16'($urandom), 1, 0, 16'h0000);
      cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    end
    chk("b2b_cnt", fetch_cnt, 16'h0007);
    cycle(0, 1, 16'h5555, 1, 0, 16'h0000);
    cycle(0, 0, 16'h0000, 1, 0, 16'h0000);
    chk("b2b_cnt_end", fetch_cnt, 16'h0008);

    // Counter wrap: preset near the top, then two more handshakes
    force dut.r_fetch_cnt = 16'hFFFE;
    #1;
    release dut.r_fetch_cnt;
    m_cnt = 16'hFFFE;
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    cycle(1, 1, 16'h0F0F, 1, 0, 16'h0000);
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    chk("wrap_ffff", fetch_cnt, 16'hFFFF);
    cycle(0, 1, 16'hF0F0, 1, 0, 16'h0000);
    cycle(0, 0, 16'h0000, 1, 0, 16'h0000);
    chk("wrap_zero", fetch_cnt, 16'h0000);

    // Asynchronous reset in the middle of a request
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);
    cycle(1, 1, 16'h9999, 0, 0, 16'h0000);
    cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    chk1("arst_pre_req", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_mem_req", mem_req, 1'b0);
    chk1("arst_ir_valid", ir_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_ir", ir, 16'h0000);
    chk("arst_cnt", fetch_cnt, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000);
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 15) != 0,
            m_fetching && ($urandom_range(0, 2) == 0),
            16'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0,
            16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mr_fetch_controller.md
MR_FETCH_CONTROLLER -- requirements
Module: mr_fetch_controller

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RST  in  1  asynchronous, active-high reset; also drive it to the program counter's RST.
REQ-003 RUN  in  1  level; 1 = keep fetching, 0 = stop after current fetch completes.
REQ-004 PC  in  16  current program-counter value.
REQ-005 PC_ENA  out  1  program-counter clock enable.
REQ-006 PC_ST  out  1  program-counter load select; effective only with PC_ENA=1.
REQ-007 PC_ADDR  out  16  program-counter load value.
REQ-008 MEM_REQ  out  1  instruction-memory read request.
REQ-009 MEM_ADDR  out  16  read address.
REQ-010 MEM_ACK  in  1  read done; MEM_DATA valid this cycle.
REQ-011 MEM_DATA  in  16  read data.
REQ-012 IR  out  16  fetched instruction.
REQ-013 IR_VALID  out  1  IR holds a deliverable instruction.
REQ-014 IR_READY  in  1  decoder accepts IR.
REQ-015 BR_REQ  in  1  one-cycle branch request from decoder.
REQ-016 BR_ADDR  in  16  branch target, sampled with BR_REQ.
REQ-017 BUSY  out  1  1 when state is not IDLE.
REQ-018 FETCH_CNT  out  16  count of instructions delivered (handshakes).

Function
REQ-019 FSM states IDLE, REQ, DELIVER, LOAD; state register plus IR, br_pend, br_addr, FETCH_CNT registers.
REQ-020 Program counter interaction: PC_ENA=1,PC_ST=0 increments; PC_ENA=1,PC_ST=1 loads PC_ADDR; PC_ENA=0 holds.
REQ-021 IDLE: br_pend=1 -> LOAD; else RUN=1 -> REQ; else stay.
REQ-022 REQ: MEM_REQ=1, MEM_ADDR=PC (combinational); MEM_REQ held until MEM_ACK, never aborted.
REQ-023 REQ with MEM_ACK=1 and no branch pending/arriving: IR<=MEM_DATA, PC_ENA=1 same cycle (Mealy), -> DELIVER.
REQ-024 REQ with MEM_ACK=1 and branch pending or BR_REQ same cycle: word discarded, IR unchanged, PC_ENA=0, -> LOAD.
REQ-025 DELIVER: IR_VALID = (state==DELIVER) & !br_pend; IR stable while IR_VALID=1 and IR_READY=0.
REQ-026 Handshake = IR_VALID & IR_READY; on handshake FETCH_CNT increments by 1, wraps 0xFFFF -> 0x0000.
REQ-027 DELIVER exit: handshake with BR_REQ=0 -> REQ if RUN else IDLE; handshake with BR_REQ=1 -> LOAD.
REQ-028 DELIVER with br_pend=1: IR flushed (no handshake possible) -> LOAD next cycle.
REQ-029 BR_REQ accepted in IDLE, REQ, DELIVER: br_pend<=1, br_addr<=BR_ADDR; new BR_REQ while pending overwrites br_addr.
REQ-030 BR_REQ in LOAD ignored.
REQ-031 LOAD (one cycle): PC_ENA=1, PC_ST=1, PC_ADDR=br_addr, br_pend<=0, -> REQ if RUN else IDLE.
REQ-032 Outside LOAD: PC_ST=0, PC_ADDR=0x0000; PC_ENA=0 except per REQ-023/031.
REQ-033 RUN=0 mid-operation: current REQ completes, DELIVER waits for handshake or flush, then IDLE; no new MEM_REQ.
REQ-034 Minimum fetch cycle, ACK on first REQ cycle and IR_READY held 1: one instruction per 2 cycles.

Reset
REQ-035 RST=1 asynchronously forces state=IDLE, IR=0x0000, br_pend=0, br_addr=0x0000, FETCH_CNT=0x0000.
REQ-036 During reset: MEM_REQ=0, PC_ENA=0, PC_ST=0, PC_ADDR=0x0000, IR_VALID=0, BUSY=0.
REQ-037 RST asserted mid-transaction abandons it; after release first MEM_REQ no earlier than cycle after RUN=1 sampled.

Verification
REQ-038 PC=0x0000, RUN=1, MEM_ACK 1 cycle after MEM_REQ, MEM_DATA=0xA5A5, IR_READY=1 -> MEM_ADDR=0x0000, IR=0xA5A5, one PC_ENA pulse, FETCH_CNT=1.
REQ-039 IR_READY=0 for 5 cycles in DELIVER -> IR_VALID=1 and IR stable all 5 cycles, FETCH_CNT unchanged, no MEM_REQ.
REQ-040 BR_REQ with BR_ADDR=0x1234 while in REQ, ACK next cycle -> word discarded, LOAD: PC_ENA=1,PC_ST=1,PC_ADDR=0x1234, next MEM_ADDR=0x1234.
REQ-041 Two BR_REQ (0x1000 then 0x2000) before ACK -> single load of 0x2000, FETCH_CNT unchanged.
REQ-042 FETCH_CNT preset by 65535 handshakes, one more handshake -> FETCH_CNT=0x0000.
REQ-043 RST pulse while MEM_REQ=1 -> MEM_REQ, IR_VALID, BUSY drop immediately without clock; all registers at reset values.
